cache_req_arbiter: RTL and testbench

- Shares one cache_system_2level read port between two requesters (0 = instruction fetch, 1 = data load) using round-robin arbitration.
- Sequences each access: latches the winner's address, issues a one-cycle read pulse, waits a fixed response latency, then captures read data and L1/L2 hit flags.
- Returns the result to the winner with a one-cycle valid pulse.
- Keeps saturating L1-hit, L2-hit and miss counters for trace statistics.

---
 rtl/cache_req_arbiter.sv | 114 +++++++++++
 tb/tb_cache_req_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache read port between instruction fetch (0) and data load (1).
// Sequences each access through ISSUE/WAIT/RESP and keeps saturating hit/miss statistics.
module cache_req_arbiter #(
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 11,
    parameter int RESP_LATENCY = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [1:0]            req,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [1:0]            grant,
    output logic [1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_l1_hit,
    output logic                  resp_l2_hit,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic                  cache_read,
    input  logic [DATA_WIDTH-1:0] cache_read_data,
    input  logic                  cache_l1_hit,
    input  logic                  cache_l2_hit,
    output logic [CNT_WIDTH-1:0]  l1_hit_cnt,
    output logic [CNT_WIDTH-1:0]  l2_hit_cnt,
    output logic [CNT_WIDTH-1:0]  miss_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t     state;
    logic [3:0] wait_cnt;
    logic       last;   // requester served most recently
    logic       pick;   // winner of the current IDLE arbitration

    always_comb begin
        pick = 1'b0;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            2'b11:   pick = ~last;
            default: pick = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            last        <= 1'b1;
            grant       <= '0;
            resp_valid  <= '0;
            resp_data   <= '0;
            resp_l1_hit <= 1'b0;
            resp_l2_hit <= 1'b0;
            busy        <= 1'b0;
            cache_addr  <= '0;
            cache_read  <= 1'b0;
            l1_hit_cnt  <= '0;
            l2_hit_cnt  <= '0;
            miss_cnt    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        grant      <= pick ? 2'b10 : 2'b01;
                        cache_addr <= pick ? addr1 : addr0;
                        cache_read <= 1'b1;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cache_read <= 1'b0;
                    wait_cnt   <= 4'(RESP_LATENCY);
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    // counter reaching zero on this edge is the capture edge
                    if (wait_cnt == 4'd1) begin
                        resp_data   <= cache_read_data;
                        resp_l1_hit <= cache_l1_hit;
                        resp_l2_hit <= cache_l2_hit;
                        resp_valid  <= grant;
                        if (cache_l1_hit) begin
                            if (l1_hit_cnt != '1) l1_hit_cnt <= l1_hit_cnt + CNT_WIDTH'(1);
                        end else if (cache_l2_hit) begin
                            if (l2_hit_cnt != '1) l2_hit_cnt <= l2_hit_cnt + CNT_WIDTH'(1);
                        end else begin
                            if (miss_cnt != '1) miss_cnt <= miss_cnt + CNT_WIDTH'(1);
                        end
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    resp_valid <= '0;
                    last       <= grant[1];
                    grant      <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Scoreboard bench for cache_req_arbiter: a behavioural cache and two requesters run from one
// per-cycle step task; expected accesses are queued at stimulus time and checked on issue/response.
module tb_cache_req_arbiter;

    localparam int AW   = 11;
    localparam int DW   = 11;
    localparam int LAT  = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [1:0]    req = 2'b00;
    logic [AW-1:0] addr0 = '0;
    logic [AW-1:0] addr1 = '0;
    logic [1:0]    grant;
    logic [1:0]    resp_valid;
    logic [DW-1:0] resp_data;
    logic          resp_l1_hit;
    logic          resp_l2_hit;
    logic          busy;
    logic [AW-1:0] cache_addr;
    logic          cache_read;
    logic [DW-1:0] cache_read_data = '0;
    logic          cache_l1_hit = 1'b0;
    logic          cache_l2_hit = 1'b0;
    logic [CW-1:0] l1_hit_cnt;
    logic [CW-1:0] l2_hit_cnt;
    logic [CW-1:0] miss_cnt;

    always #5 clk = ~clk;

    cache_req_arbiter #(
        .ADDR_WIDTH  (AW),
        .DATA_WIDTH  (DW),
        .RESP_LATENCY(LAT),
        .CNT_WIDTH   (CW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .addr0          (addr0),
        .addr1          (addr1),
        .grant          (grant),
        .resp_valid     (resp_valid),
        .resp_data      (resp_data),
        .resp_l1_hit    (resp_l1_hit),
        .resp_l2_hit    (resp_l2_hit),
        .busy           (busy),
        .cache_addr     (cache_addr),
        .cache_read     (cache_read),
        .cache_read_data(cache_read_data),
        .cache_l1_hit   (cache_l1_hit),
        .cache_l2_hit   (cache_l2_hit),
        .l1_hit_cnt     (l1_hit_cnt),
        .l2_hit_cnt     (l2_hit_cnt),
        .miss_cnt       (miss_cnt)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    gnt;
        logic [DW-1:0] data;
        logic          l1;
        logic          l2;
    } acc_t;

    acc_t          issue_q[$];
    acc_t          resp_q[$];
    logic [AW-1:0] rq0[$];
    logic [AW-1:0] rq1[$];

    int            compared   = 0;
    int            mismatched = 0;
    int            cyc        = 0;
    int            grant_cyc  = 0;
    int            m_l1 = 0, m_l2 = 0, m_miss = 0;
    logic          prev_read  = 1'b0;
    logic [1:0]    prev_grant = 2'b00;
    logic [1:0]    prev_resp  = 2'b00;
    logic [AW-1:0] cur_addr   = '0;
    logic          kill       = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_counters();
        check("l1_hit_cnt", l1_hit_cnt, m_l1);
        check("l2_hit_cnt", l2_hit_cnt, m_l2);
        check("miss_cnt", miss_cnt, m_miss);
    endtask

    task automatic access(input int who, input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic l1, input logic l2);
        acc_t e;
        e.addr = a;
        e.gnt  = (who == 0) ? 2'b01 : 2'b10;
        e.data = d;
        e.l1   = l1;
        e.l2   = l2;
        issue_q.push_back(e);
        if (who == 0) rq0.push_back(a);
        else rq1.push_back(a);
    endtask

    // One clock cycle: observe at the falling edge, then update cache model and requesters.
    task automatic step();
        acc_t e;
        @(negedge clk);
        cyc++;
        if (grant != 2'b00) begin
            check("grant_onehot", $countones(grant), 1);
            if (prev_grant == 2'b00) grant_cyc = cyc;
            else check("addr_hold", cache_addr, cur_addr);
        end
        if (cache_read) begin
            check("read_pulse", prev_read, 0);
            check("busy_issue", busy, 1);
            if (issue_q.size() == 0) begin
                check("unexpected_issue", issue_q.size(), 1);
            end else begin
                e = issue_q.pop_front();
                check("issue_addr", cache_addr, e.addr);
                check("issue_grant", grant, e.gnt);
                check("issue_vs_grant", cyc - grant_cyc, 0);
                cur_addr        = cache_addr;
                cache_read_data = e.data;
                cache_l1_hit    = e.l1;
                cache_l2_hit    = e.l2;
                resp_q.push_back(e);
            end
        end
        if (resp_valid != 2'b00) begin
            check("resp_pulse", prev_resp, 0);
            if (resp_q.size() == 0) begin
                check("unexpected_resp", resp_q.size(), 1);
            end else begin
                e = resp_q.pop_front();
                check("resp_valid", resp_valid, e.gnt);
                check("resp_data", resp_data, e.data);
                check("resp_l1", resp_l1_hit, e.l1);
                check("resp_l2", resp_l2_hit, e.l2);
                check("resp_latency", cyc - grant_cyc, LAT + 1);
                if (e.l1) begin
                    if (m_l1 < CMAX) m_l1++;
                end else if (e.l2) begin
                    if (m_l2 < CMAX) m_l2++;
                end else begin
                    if (m_miss < CMAX) m_miss++;
                end
                check_counters();
            end
        end
        prev_read  = cache_read;
        prev_grant = grant;
        prev_resp  = resp_valid;
        if (kill) begin
            rq0.delete();
            rq1.delete();
            req = 2'b00;
        end else begin
            if (resp_valid[0] && rq0.size() != 0) void'(rq0.pop_front());
            if (resp_valid[1] && rq1.size() != 0) void'(rq1.pop_front());
            req[0] = (rq0.size() != 0);
            req[1] = (rq1.size() != 0);
            if (req[0]) addr0 = rq0[0];
            if (req[1]) addr1 = rq1[0];
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        kill  = 1'b1;
        step();
        step();
        check("rst_grant", grant, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_data", resp_data, 0);
        check("rst_resp_l1", resp_l1_hit, 0);
        check("rst_resp_l2", resp_l2_hit, 0);
        check("rst_busy", busy, 0);
        check("rst_cache_addr", cache_addr, 0);
        check("rst_cache_read", cache_read, 0);
        check("rst_l1_cnt", l1_hit_cnt, 0);
        check("rst_l2_cnt", l2_hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        kill  = 1'b0;
        issue_q.delete();
        resp_q.delete();
        m_l1 = 0;
        m_l2 = 0;
        m_miss = 0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((rq0.size() + rq1.size() + issue_q.size() + resp_q.size()) != 0 && n < 400) begin
            step();
            n++;
        end
        check(tag, rq0.size() + rq1.size() + issue_q.size() + resp_q.size(), 0);
        step();
        step();
        check("idle_busy", busy, 0);
        check("idle_grant", grant, 0);
    endtask

    initial begin
        bit saw;

        do_reset();

        // single read, miss
        access(0, 11'h123, 11'h456, 1'b0, 1'b0);
        drain("single_timeout");
        check("single_miss", miss_cnt, 1);
        check("single_l1", l1_hit_cnt, 0);
        check("single_l2", l2_hit_cnt, 0);

        // tie straight after reset: requester 0 first
        do_reset();
        access(0, 11'h123, DW'($urandom), 1'b0, 1'b1);
        access(1, 11'h2A3, DW'($urandom), 1'b1, 1'b0);
        drain("tie_timeout");

        // fairness: both keep requesting, grants alternate starting with 0
        for (int i = 0; i < 3; i++) begin
            access(0, AW'(11'h010 + i), DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            access(1, AW'(11'h700 + i), DW'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain("fair_timeout");

        // hit classification, L1 priority over L2
        do_reset();
        access(0, 11'h031, 11'h001, 1'b1, 1'b0);
        access(0, 11'h032, 11'h002, 1'b0, 1'b1);
        access(0, 11'h033, 11'h003, 1'b1, 1'b1);
        drain("class_timeout");
        check("class_l1", l1_hit_cnt, 2);
        check("class_l2", l2_hit_cnt, 1);
        check("class_miss", miss_cnt, 0);

        // reset during WAIT abandons the access
        access(0, 11'h345, 11'h3FF, 1'b1, 1'b0);
        saw = 1'b0;
        for (int i = 0; i < 50 && !saw; i++) begin
            step();
            saw = cache_read;
        end
        check("midrst_issue_seen", saw, 1);
        step();
        rst_n = 1'b0;
        kill  = 1'b1;
        step();
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_read", cache_read, 0);
        check("midrst_resp", resp_valid, 0);
        check("midrst_l1", l1_hit_cnt, 0);
        check("midrst_l2", l2_hit_cnt, 0);
        check("midrst_miss", miss_cnt, 0);
        rst_n = 1'b1;
        kill  = 1'b0;
        resp_q.delete();
        issue_q.delete();
        m_l1 = 0;
        m_l2 = 0;
        m_miss = 0;
        for (int i = 0; i < 10; i++) step();
        access(1, 11'h200, 11'h155, 1'b0, 1'b0);
        drain("after_rst_timeout");

        // saturation of the L1 counter
        do_reset();
        for (int i = 0; i < 17; i++) access(0, AW'(11'h400 + i), DW'($urandom), 1'b1, 1'($urandom_range(0, 1)));
        drain("sat_timeout");
        check("sat_l1", l1_hit_cnt, 15);
        check("sat_miss", miss_cnt, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
